// File: rtl/minesweeper_game_ctrl.sv
// Minesweeper game sequencer: cursor moves, LFSR mine placement, serial neighbour count, win/lose.
// Defining MINESWEEPER_FLAG_EN builds flag storage and the btn_flag toggle.
module minesweeper_game_ctrl #(
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int MINES = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_press,
  input  logic       btn_flag,
  input  logic [4:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [3:0] rd_tile,
  output logic [4:0] cur_x,
  output logic [3:0] cur_y,
  output logic [1:0] game_state,
  output logic       busy
);
  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0] XMAX = 5'(COLS - 1);
  localparam logic [3:0] YMAX = 4'(ROWS - 1);
  localparam logic [5:0] XLIM = 6'(COLS);
  localparam logic [4:0] YLIM = 5'(ROWS);
  localparam logic signed [6:0] XLIM_S = 7'(COLS);
  localparam logic signed [5:0] YLIM_S = 6'(ROWS);
  localparam logic [8:0] LAST_MINE = 9'(MINES - 1);
  localparam logic [8:0] LAST_SAFE = 9'(N - MINES - 1);

  typedef enum logic [2:0] {S_READY, S_PLAY, S_LOST, S_WON, S_SEED, S_COUNT} state_t;
  state_t state, state_nxt;

  logic [N-1:0]    mine, revealed, flagged;
  logic [3:0]      cnt [N];
  logic [15:0]     lfsr;
  logic [5:0]      btn_now, btn_last, btn_ev;
  logic [8:0]      placed, revealed_total;
  logic [4:0]      tgt_x, mv_x, cand_x;
  logic [3:0]      tgt_y, mv_y, cand_y;
  logic [3:0]      nbr_k, nbr_acc;
  logic [IW-1:0]   mv_idx, boom_idx, rd_idx;
  logic            cand_ok, nb_mine;
  logic signed [6:0] nb_x;
  logic signed [5:0] nb_y;
  logic            seed_start, place_mine, start_count, write_count, explode, clear_board;

  function automatic logic [IW-1:0] tidx(input logic [4:0] x, input logic [3:0] y);
    return IW'(int'(y) * COLS + int'(x));
  endfunction

  assign btn_now = {btn_flag, btn_press, btn_down, btn_up, btn_right, btn_left};
  assign btn_ev  = btn_last & ~btn_now;
  assign busy    = (state == S_SEED) || (state == S_COUNT);

  // Cursor after this cycle's moves; a press in the same cycle acts on this tile
  always_comb begin
    mv_x = cur_x;
    mv_y = cur_y;
    if (!busy) begin
      if (btn_ev[3]) begin
        if (cur_y != YMAX) mv_y = cur_y + 4'd1;
      end else if (btn_ev[2]) begin
        if (cur_y != 4'd0) mv_y = cur_y - 4'd1;
      end
      if (btn_ev[0]) begin
        if (cur_x != 5'd0) mv_x = cur_x - 5'd1;
      end else if (btn_ev[1]) begin
        if (cur_x != XMAX) mv_x = cur_x + 5'd1;
      end
    end
  end
  assign mv_idx = tidx(mv_x, mv_y);

  assign cand_x  = lfsr[4:0];
  assign cand_y  = lfsr[8:5];
  assign cand_ok = ({1'b0, cand_x} < XLIM) && ({1'b0, cand_y} < YLIM) &&
                   !mine[tidx(cand_x, cand_y)] && !((cand_x == tgt_x) && (cand_y == tgt_y));

  // Neighbour offset for scan step nbr_k: NW,N,NE,W,E,SW,S,SE
  always_comb begin
    nb_x = $signed({2'b00, tgt_x});
    nb_y = $signed({2'b00, tgt_y});
    case (nbr_k[2:0])
      3'd0: begin nb_x = nb_x - 7'sd1; nb_y = nb_y - 6'sd1; end
      3'd1: nb_y = nb_y - 6'sd1;
      3'd2: begin nb_x = nb_x + 7'sd1; nb_y = nb_y - 6'sd1; end
      3'd3: nb_x = nb_x - 7'sd1;
      3'd4: nb_x = nb_x + 7'sd1;
      3'd5: begin nb_x = nb_x - 7'sd1; nb_y = nb_y + 6'sd1; end
      3'd6: nb_y = nb_y + 6'sd1;
      default: begin nb_x = nb_x + 7'sd1; nb_y = nb_y + 6'sd1; end
    endcase
    nb_mine = !nb_x[6] && !nb_y[5] && (nb_x < XLIM_S) && (nb_y < YLIM_S) &&
              mine[tidx(nb_x[4:0], nb_y[3:0])];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_READY;
    else        state <= state_nxt;
  end

`ifdef MINESWEEPER_FLAG_EN
  logic flag_tog;
`endif

  always_comb begin
    state_nxt   = state;
    seed_start  = 1'b0;
    place_mine  = 1'b0;
    start_count = 1'b0;
    write_count = 1'b0;
    explode     = 1'b0;
    clear_board = 1'b0;
`ifdef MINESWEEPER_FLAG_EN
    flag_tog    = 1'b0;
`endif
    case (state)
      S_READY: if (btn_ev[4]) begin
        state_nxt  = S_SEED;
        seed_start = 1'b1;
      end
      S_SEED: if (cand_ok) begin
        place_mine = 1'b1;
        if (placed == LAST_MINE) begin
          state_nxt   = S_COUNT;
          start_count = 1'b1;
        end
      end
      S_PLAY: begin
        if (btn_ev[4] && !revealed[mv_idx] && !flagged[mv_idx]) begin
          if (mine[mv_idx]) begin
            state_nxt = S_LOST;
            explode   = 1'b1;
          end else begin
            state_nxt   = S_COUNT;
            start_count = 1'b1;
          end
        end
`ifdef MINESWEEPER_FLAG_EN
        else if (btn_ev[5] && !btn_ev[4] && !revealed[mv_idx]) flag_tog = 1'b1;
`endif
      end
      S_COUNT: if (nbr_k == 4'd8) begin
        write_count = 1'b1;
        state_nxt   = (revealed_total == LAST_SAFE) ? S_WON : S_PLAY;
      end
      S_LOST, S_WON: if (btn_ev[4]) begin
        state_nxt   = S_READY;
        clear_board = 1'b1;
      end
      default: state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x          <= 5'd0;
      cur_y          <= 4'd0;
      btn_last       <= 6'd0;
      lfsr           <= 16'hACE1;
      mine           <= '0;
      revealed       <= '0;
      cnt            <= '{default: 4'd0};
      placed         <= 9'd0;
      revealed_total <= 9'd0;
      tgt_x          <= 5'd0;
      tgt_y          <= 4'd0;
      nbr_k          <= 4'd0;
      nbr_acc        <= 4'd0;
      boom_idx       <= '0;
    end else begin
      btn_last <= btn_now;
      lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cur_x    <= mv_x;
      cur_y    <= mv_y;
      if (seed_start) placed <= 9'd0;
      if (place_mine) begin
        mine[tidx(cand_x, cand_y)] <= 1'b1;
        placed <= placed + 9'd1;
      end
      // From SEED the target is already the safe tile, and the cursor cannot move while busy
      if (seed_start || start_count) begin
        tgt_x <= mv_x;
        tgt_y <= mv_y;
      end
      if (start_count) begin
        nbr_k   <= 4'd0;
        nbr_acc <= 4'd0;
      end else if (state == S_COUNT && nbr_k != 4'd8) begin
        nbr_k   <= nbr_k + 4'd1;
        nbr_acc <= nbr_acc + {3'b000, nb_mine};
      end
      if (write_count) begin
        cnt[tidx(tgt_x, tgt_y)]      <= nbr_acc;
        revealed[tidx(tgt_x, tgt_y)] <= 1'b1;
        revealed_total               <= revealed_total + 9'd1;
      end
      if (explode) boom_idx <= mv_idx;
      if (clear_board) begin
        mine           <= '0;
        revealed       <= '0;
        cnt            <= '{default: 4'd0};
        placed         <= 9'd0;
        revealed_total <= 9'd0;
      end
    end
  end

`ifdef MINESWEEPER_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           flagged <= '0;
    else if (clear_board) flagged <= '0;
    else if (flag_tog)    flagged[mv_idx] <= ~flagged[mv_idx];
  end
`else
  logic unused_flag_ev;
  assign flagged        = '0;
  assign unused_flag_ev = btn_ev[5];
`endif

  always_comb begin
    case (state)
      S_READY: game_state = 2'd0;
      S_LOST:  game_state = 2'd2;
      S_WON:   game_state = 2'd3;
      default: game_state = 2'd1;
    endcase
  end

  // Renderer read port; in LOST mines are exposed even when flagged
  always_comb begin
    rd_idx  = tidx(rd_x, rd_y);
    rd_tile = 4'd9;
    if (({1'b0, rd_x} < XLIM) && ({1'b0, rd_y} < YLIM)) begin
      if (state == S_LOST && rd_idx == boom_idx)  rd_tile = 4'd12;
      else if (state == S_LOST && mine[rd_idx])   rd_tile = 4'd11;
      else if (revealed[rd_idx])                  rd_tile = cnt[rd_idx];
      else if (flagged[rd_idx])                   rd_tile = 4'd10;
    end
  end
endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// Bench for minesweeper_game_ctrl: a board-level game model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_minesweeper_game_ctrl;
  localparam int COLS = 20, ROWS = 15, MINES = 40, N = COLS * ROWS;
`ifdef MINESWEEPER_FLAG_EN
  localparam bit FLAG_EN = 1'b1;
`else
  localparam bit FLAG_EN = 1'b0;
`endif
  localparam bit [5:0] BL = 6'b000001, BR = 6'b000010, BU = 6'b000100,
                       BD = 6'b001000, BP = 6'b010000, BF = 6'b100000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0, btn_press = 0, btn_flag = 0;
  logic [4:0] rd_x = 5'd0;
  logic [3:0] rd_y = 4'd0;
  logic [3:0] rd_tile;
  logic [4:0] cur_x;
  logic [3:0] cur_y;
  logic [1:0] game_state;
  logic       busy;

  always #5 clk = ~clk;

  minesweeper_game_ctrl #(.COLS(COLS), .ROWS(ROWS), .MINES(MINES)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_press(btn_press), .btn_flag(btn_flag),
    .rd_x(rd_x), .rd_y(rd_y), .rd_tile(rd_tile),
    .cur_x(cur_x), .cur_y(cur_y), .game_state(game_state), .busy(busy)
  );

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  bit  m_mine[ROWS][COLS], m_rev[ROWS][COLS], m_flag[ROWS][COLS];
  int  m_cnt[ROWS][COLS];
  int  m_cx, m_cy, m_gs, m_placed, m_revn, m_tx, m_ty, m_bx, m_by, m_cdown;
  bit  m_seeding;
  logic [15:0] m_lfsr;
  bit  [5:0]   m_last;

  task automatic m_clear();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        m_mine[y][x] = 0; m_rev[y][x] = 0; m_flag[y][x] = 0; m_cnt[y][x] = 0;
      end
    m_placed = 0; m_revn = 0;
  endtask

  task automatic model_reset();
    m_clear();
    m_cx = 0; m_cy = 0; m_gs = 0; m_tx = 0; m_ty = 0; m_bx = -1; m_by = -1;
    m_cdown = 0; m_seeding = 0; m_lfsr = 16'hACE1; m_last = '0;
  endtask

  function automatic bit m_busy();
    return m_seeding || (m_cdown > 0);
  endfunction

  function automatic int nbr(input int x, input int y);
    int c = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < COLS && y + dy >= 0 && y + dy < ROWS)
          if (m_mine[y + dy][x + dx]) c++;
    return c;
  endfunction

  function automatic int m_tile(input int x, input int y);
    if (x >= COLS || y >= ROWS) return 9;
    if (m_gs == 2 && x == m_bx && y == m_by) return 12;
    if (m_gs == 2 && m_mine[y][x]) return 11;
    if (m_rev[y][x]) return m_cnt[y][x];
    if (m_flag[y][x]) return 10;
    return 9;
  endfunction

  task automatic model_step();
    bit [5:0] now, ev;
    logic [15:0] lf;
    int x, y, cx, cy;
    bit bsy;
    now = {btn_flag, btn_press, btn_down, btn_up, btn_right, btn_left};
    ev = m_last & ~now;
    m_last = now;
    lf = m_lfsr;
    m_lfsr = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    bsy = m_busy();
    x = m_cx; y = m_cy;
    if (!bsy) begin
      if (ev[3]) y = (y < ROWS - 1) ? y + 1 : y;
      else if (ev[2]) y = (y > 0) ? y - 1 : y;
      if (ev[0]) x = (x > 0) ? x - 1 : x;
      else if (ev[1]) x = (x < COLS - 1) ? x + 1 : x;
    end
    if (m_seeding) begin
      cx = int'(lf[4:0]); cy = int'(lf[8:5]);
      if (cx < COLS && cy < ROWS && !(cx == m_tx && cy == m_ty)) begin
        if (!m_mine[cy][cx]) begin
          m_mine[cy][cx] = 1; m_placed++;
          if (m_placed == MINES) begin m_seeding = 0; m_cdown = 9; end
        end
      end
    end else if (m_cdown > 0) begin
      m_cdown--;
      if (m_cdown == 0) begin
        m_cnt[m_ty][m_tx] = nbr(m_tx, m_ty);
        m_rev[m_ty][m_tx] = 1;
        m_revn++;
        m_gs = (m_revn == N - MINES) ? 3 : 1;
      end
    end else if (ev[4]) begin
      if (m_gs == 0) begin
        m_seeding = 1; m_gs = 1; m_tx = x; m_ty = y; m_placed = 0;
      end else if (m_gs == 1) begin
        if (!m_rev[y][x] && !m_flag[y][x]) begin
          if (m_mine[y][x]) begin m_gs = 2; m_bx = x; m_by = y; end
          else begin m_tx = x; m_ty = y; m_cdown = 9; end
        end
      end else begin
        m_clear(); m_gs = 0;
      end
    end else if (ev[5] && FLAG_EN && m_gs == 1 && !m_rev[y][x]) begin
      m_flag[y][x] = !m_flag[y][x];
    end
    m_cx = x; m_cy = y;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cur_x", 16'(cur_x), 16'(m_cx));
      chk("cur_y", 16'(cur_y), 16'(m_cy));
      chk("game_state", 16'(game_state), 16'(m_gs));
      chk("busy", 16'(busy), 16'(m_busy()));
      chk("rd_tile", 16'(rd_tile), 16'(m_tile(int'(rd_x), int'(rd_y))));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rel(input bit [5:0] m);
    {btn_flag, btn_press, btn_down, btn_up, btn_right, btn_left} = m;
    step();
    {btn_flag, btn_press, btn_down, btn_up, btn_right, btn_left} = 6'b0;
    step();
  endtask

  task automatic goto(input int tx, input int ty);
    bit [5:0] m;
    for (int i = 0; i < 64; i++) begin
      if (m_cx == tx && m_cy == ty) break;
      m = 6'b0;
      if (m_cx < tx) m |= BR; else if (m_cx > tx) m |= BL;
      if (m_cy < ty) m |= BD; else if (m_cy > ty) m |= BU;
      rel(m);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((busy === 1'b1 || m_busy()) && i < 400) begin step(); i++; end
    chk("idle_bound", 16'(busy), 16'd0);
  endtask

  int hist[16];
  task automatic sweep();
    for (int k = 0; k < 16; k++) hist[k] = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        rd_x = 5'(x); rd_y = 4'(y);
        #1;
        if (rd_tile < 4'd13) hist[rd_tile]++;
        step();
      end
  endtask

  task automatic peek(input string nm, input int x, input int y, input int exp);
    rd_x = 5'(x); rd_y = 4'(y);
    #1;
    chk(nm, 16'(rd_tile), 16'(exp));
  endtask

  task automatic hit_reset(input string nm);
    rst_n = 1'b0;
    #1;
    chk({nm, "_gs"}, 16'(game_state), 16'd0);
    chk({nm, "_busy"}, 16'(busy), 16'd0);
    chk({nm, "_cx"}, 16'(cur_x), 16'd0);
    step();
    rst_n = 1'b1;
    sweep();
    chk({nm, "_all_hidden"}, 16'(hist[9]), 16'(N));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected $finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int c, mx, my, sx, sy;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    // Reset state
    chk("t1_cur_x", 16'(cur_x), 16'd0);
    chk("t1_cur_y", 16'(cur_y), 16'd0);
    chk("t1_gs", 16'(game_state), 16'd0);
    chk("t1_busy", 16'(busy), 16'd0);
    peek("t1_rd_0_0", 0, 0, 9);
    peek("t1_rd_19_14", 19, 14, 9);
    peek("t1_rd_25_3", 25, 3, 9);

    // Cursor clamping and axis priority
    repeat (25) rel(BR);
    repeat (20) rel(BD);
    chk("t2_clamp_x", 16'(cur_x), 16'd19);
    chk("t2_clamp_y", 16'(cur_y), 16'd14);
    rel(BU); rel(BU);
    rel(BU | BD);
    chk("t2_down_wins", 16'(cur_y), 16'd13);
    rel(BL | BR);
    chk("t2_left_wins", 16'(cur_x), 16'd18);

    // First reveal seeds the board
    goto(5, 5);
    rel(BP);
    chk("t3_busy", 16'(busy), 16'd1);
    wait_idle();
    chk("t3_gs", 16'(game_state), 16'd1);
    c = 0;
    for (int y = 0; y < ROWS; y++) for (int x = 0; x < COLS; x++) c += int'(m_mine[y][x]);
    chk("t3_mine_total", 16'(c), 16'd40);
    chk("t3_safe_not_mine", 16'(m_mine[5][5]), 16'd0);
    peek("t3_rd_5_5", 5, 5, nbr(5, 5));

    // Explode on a mine, then restart
    mx = 0; my = 0;
    for (int i = N - 1; i >= 0; i--) if (m_mine[i / COLS][i % COLS]) begin mx = i % COLS; my = i / COLS; end
    goto(mx, my);
    rel(BP);
    chk("t4_gs_lost", 16'(game_state), 16'd2);
    peek("t4_boom", mx, my, 12);
    sweep();
    chk("t4_exploded_cnt", 16'(hist[12]), 16'd1);
    chk("t4_mine_cnt", 16'(hist[11]), 16'd39);
    rel(BP);
    chk("t4_gs_ready", 16'(game_state), 16'd0);
    sweep();
    chk("t4_cleared", 16'(hist[9]), 16'(N));

    // Win by revealing every safe tile; inputs during busy are dropped
    rel(BP);
    wait_idle();
    sx = -1; sy = -1;
    for (int i = N - 1; i >= 0; i--)
      if (!m_mine[i / COLS][i % COLS] && !m_rev[i / COLS][i % COLS]) begin sx = i % COLS; sy = i / COLS; end
    goto(sx, sy);
    rel(BP);
    rel((sx > 0) ? BL : BR);
    rel(BP);
    wait_idle();
    chk("t5_drop_x", 16'(cur_x), 16'(sx));
    chk("t5_drop_y", 16'(cur_y), 16'(sy));
    for (int y = 0; y < ROWS; y++)
      for (int i = 0; i < COLS; i++) begin
        int x;
        x = (y % 2 == 0) ? i : COLS - 1 - i;
        goto(x, y);
        if (!m_mine[y][x] && !m_rev[y][x]) begin
          rel(BP);
          wait_idle();
        end
      end
    chk("t5_gs_won", 16'(game_state), 16'd3);
    rel(BP);
    chk("t5_gs_ready", 16'(game_state), 16'd0);

    // Asynchronous reset mid-SEED and mid-COUNT
    rel(BP);
    step();
    chk("t6_seed_busy", 16'(busy), 16'd1);
    hit_reset("t6_seed");
    rel(BP);
    wait_idle();
    sx = -1; sy = -1;
    for (int i = N - 1; i >= 0; i--)
      if (!m_mine[i / COLS][i % COLS] && !m_rev[i / COLS][i % COLS]) begin sx = i % COLS; sy = i / COLS; end
    goto(sx, sy);
    rel(BP);
    repeat (3) step();
    chk("t6_count_busy", 16'(busy), 16'd1);
    hit_reset("t6_count");

`ifdef MINESWEEPER_FLAG_EN
    // Flagged tile ignores press
    rel(BP);
    wait_idle();
    goto(3, 3);
    rel(BF);
    peek("t7_flagged", 3, 3, 10);
    rel(BP);
    peek("t7_flag_kept", 3, 3, 10);
    chk("t7_gs", 16'(game_state), 16'd1);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
